// File: rtl/ps2_key_pkg.sv
// Shared constants, prefix-FSM state type and the PS/2 set-2 letter map
// for the PS/2 letter queue.
package ps2_key_pkg;

    localparam logic [7:0]  SC_BREAK = 8'hF0;
    localparam logic [7:0]  SC_EXT   = 8'hE0;
    localparam int unsigned LETTER_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    // Make code of A..Z to index 1..26; anything else is 0 (not a letter)
    function automatic logic [LETTER_W-1:0] scan_to_idx(input logic [7:0] code);
        logic [LETTER_W-1:0] idx;
        case (code)
            8'h1C: idx = 5'd1;
            8'h32: idx = 5'd2;
            8'h21: idx = 5'd3;
            8'h23: idx = 5'd4;
            8'h24: idx = 5'd5;
            8'h2B: idx = 5'd6;
            8'h34: idx = 5'd7;
            8'h33: idx = 5'd8;
            8'h43: idx = 5'd9;
            8'h3B: idx = 5'd10;
            8'h42: idx = 5'd11;
            8'h4B: idx = 5'd12;
            8'h3A: idx = 5'd13;
            8'h31: idx = 5'd14;
            8'h44: idx = 5'd15;
            8'h4D: idx = 5'd16;
            8'h15: idx = 5'd17;
            8'h2D: idx = 5'd18;
            8'h1B: idx = 5'd19;
            8'h2C: idx = 5'd20;
            8'h3C: idx = 5'd21;
            8'h2A: idx = 5'd22;
            8'h1D: idx = 5'd23;
            8'h22: idx = 5'd24;
            8'h35: idx = 5'd25;
            8'h1A: idx = 5'd26;
            default: idx = 5'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/letter_fifo.sv
// Synchronous FIFO of letter indices. A push into a full queue is accepted
// only when a pop happens in the same cycle; a pop of an empty queue is ignored.
module letter_fifo #(
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned IDX_W      = 5,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [IDX_W-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] fill_o
);

    logic [IDX_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Status decode and next pointer/occupancy values
    always_comb begin
        full_o   = (count_q == CNT_W'(FIFO_DEPTH));
        empty_o  = (count_q == '0);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written, reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign fill_o = count_q;

endmodule

// File: rtl/ps2_letter_queue.sv
// PS/2 letter queue: tracks break/extended prefixes, turns letter make codes
// into indices 1..26 and queues them towards the rotor core.
// Build option PS2_TYPEMATIC_EN: when defined, repeated makes of the held
// letter (auto-repeat) push further indices; otherwise they are suppressed.
module ps2_letter_queue
    import ps2_key_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned IDX_W      = 5,
    localparam int unsigned FILL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        scan_byte,
    input  logic              scan_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              key_held,
    output logic              overflow,
    output logic [FILL_W-1:0] fill
);

    ps2_state_e          state_q, state_d;
    logic [7:0]          held_code_q, held_code_d;
    logic                held_vld_q, held_vld_d;
    logic                overflow_q, overflow_d;
    logic [LETTER_W-1:0] letter_c;
    logic                push_c, pop_c;
    logic                fifo_full, fifo_empty;
    logic [IDX_W-1:0]    fifo_head;

    // Prefix FSM, held-letter tracking and push/overflow decisions
    always_comb begin
        state_d     = state_q;
        held_code_d = held_code_q;
        held_vld_d  = held_vld_q;
        push_c      = 1'b0;
        letter_c    = scan_to_idx(scan_byte);
        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    if (scan_byte == SC_BREAK) begin
                        state_d = BRK;
                    end else if (scan_byte == SC_EXT) begin
                        state_d = EXT;
                    end else if (letter_c != '0) begin
                        if (held_vld_q && (held_code_q == scan_byte)) begin
`ifdef PS2_TYPEMATIC_EN
                            push_c = 1'b1;
`else
                            push_c = 1'b0;
`endif
                        end else begin
                            push_c      = 1'b1;
                            held_code_d = scan_byte;
                            held_vld_d  = 1'b1;
                        end
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (held_vld_q && (held_code_q == scan_byte)) begin
                        held_vld_d = 1'b0;
                    end
                end
                EXT: begin
                    state_d = (scan_byte == SC_BREAK) ? EXT_BRK : IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        pop_c      = out_valid && out_ready;
        overflow_d = push_c && fifo_full && !pop_c;
    end

    // State, held-code and overflow-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            held_code_q <= 8'h00;
            held_vld_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_code_q <= held_code_d;
            held_vld_q  <= held_vld_d;
            overflow_q  <= overflow_d;
        end
    end

    letter_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .IDX_W      (IDX_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .push_data_i (IDX_W'(letter_c)),
        .pop_i       (pop_c),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .fill_o      (fill)
    );

    // Head of queue, forced to 0 while the queue is empty
    always_comb begin
        out_valid = !fifo_empty;
        out_idx   = fifo_empty ? '0 : fifo_head;
    end

    assign key_held = held_vld_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_letter_queue.sv
// Self-checking bench for ps2_letter_queue: a directed vector table, a few
// hand-written multi-cycle sequences and randomized traffic against a model.
module tb_ps2_letter_queue;

    localparam int DEPTH = 4;
    localparam int IDXW  = 5;
`ifdef PS2_TYPEMATIC_EN
    localparam int TM = 1;
`else
    localparam int TM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  scan_byte = 8'h00;
    logic        scan_valid = 1'b0;
    logic [IDXW-1:0] out_idx;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        key_held;
    logic        overflow;
    logic [$clog2(DEPTH):0] fill;

    ps2_letter_queue #(.FIFO_DEPTH(DEPTH), .IDX_W(IDXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_byte  (scan_byte),
        .scan_valid (scan_valid),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_held   (key_held),
        .overflow   (overflow),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    int         mq[$];
    logic [7:0] m_held;
    bit         m_held_v, m_brk, m_ext, m_ovf;

    function automatic int letter_of(input logic [7:0] b);
        for (int i = 0; i < 26; i++) if (codes[i] == b) return i + 1;
        return 0;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_held = 8'h00; m_held_v = 0; m_brk = 0; m_ext = 0; m_ovf = 0;
    endfunction

    function automatic void model_update(input logic [7:0] b, input bit v, input bit r);
        int  size0 = mq.size();
        bit  pop   = (size0 > 0) && r;
        bit  want  = 0;
        int  idx   = 0;
        if (v) begin
            if (m_ext && m_brk) begin
                m_ext = 0; m_brk = 0;
            end else if (m_brk) begin
                if (m_held_v && b == m_held) m_held_v = 0;
                m_brk = 0;
            end else if (m_ext) begin
                if (b == 8'hF0) m_brk = 1; else m_ext = 0;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else begin
                idx = letter_of(b);
                if (idx != 0) begin
                    if (m_held_v && m_held == b) want = (TM != 0);
                    else begin
                        want = 1; m_held = b; m_held_v = 1;
                    end
                end
            end
        end
        if (pop) void'(mq.pop_front());
        m_ovf = 0;
        if (want) begin
            if (size0 < DEPTH || pop) mq.push_back(idx);
            else m_ovf = 1;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".fill"},  int'(fill), mq.size());
        chk({tag, ".valid"}, int'(out_valid), (mq.size() > 0) ? 1 : 0);
        chk({tag, ".idx"},   int'(out_idx), (mq.size() > 0) ? mq[0] : 0);
        chk({tag, ".held"},  int'(key_held), int'(m_held_v));
        chk({tag, ".ovf"},   int'(overflow), int'(m_ovf));
    endtask

    // Inputs change on the falling edge; outputs are compared one falling edge later
    task automatic drive_cycle(input logic [7:0] b, input bit v, input bit r);
        scan_byte = b; scan_valid = v; out_ready = r;
        @(posedge clk);
        model_update(b, v, r);
        @(negedge clk);
        scan_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic step(input string tag, input logic [7:0] b, input bit v, input bit r);
        drive_cycle(b, v, r);
        chk_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; scan_valid = 1'b0; out_ready = 1'b0;
        #1;
        model_reset();
        chk({tag, ".fill"},  int'(fill), 0);
        chk({tag, ".valid"}, int'(out_valid), 0);
        chk({tag, ".idx"},   int'(out_idx), 0);
        chk({tag, ".held"},  int'(key_held), 0);
        chk({tag, ".ovf"},   int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] b;
        bit         v;
        bit         r;
        int         e_fill;
        int         e_idx;
        int         e_held;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [7:0] b, input bit v, input bit r,
                                input int f, input int idx, input int h);
        vec_t t;
        t.b = b; t.v = v; t.r = r; t.e_fill = f; t.e_idx = idx; t.e_held = h;
        return t;
    endfunction

    int ov_codes [5];
    int exp_a [4];
    int ovf_seen;
    logic [7:0] rb;

    initial begin
        tbl[0]  = mk(8'h1C, 1, 0, 1, 1, 1);
        tbl[1]  = mk(8'hF0, 1, 0, 1, 1, 1);
        tbl[2]  = mk(8'h1C, 1, 0, 1, 1, 0);
        tbl[3]  = mk(8'h00, 0, 1, 0, 0, 0);
        tbl[4]  = mk(8'hE0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(8'h1C, 1, 0, 0, 0, 0);
        tbl[6]  = mk(8'hE0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(8'hF0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(8'h1C, 1, 0, 0, 0, 0);
        tbl[9]  = mk(8'h1A, 1, 0, 1, 26, 1);
        tbl[10] = mk(8'h1A, 1, 0, 1 + TM, 26, 1);
        tbl[11] = mk(8'h1A, 1, 0, 1 + 2 * TM, 26, 1);
        tbl[12] = mk(8'hF0, 1, 0, 1 + 2 * TM, 26, 1);
        tbl[13] = mk(8'h1A, 1, 0, 1 + 2 * TM, 26, 0);

        @(negedge clk);
        do_reset("reset0");

        for (int i = 0; i < 14; i++) begin
            drive_cycle(tbl[i].b, tbl[i].v, tbl[i].r);
            chk($sformatf("tbl%0d.fill", i),  int'(fill), tbl[i].e_fill);
            chk($sformatf("tbl%0d.valid", i), int'(out_valid), (tbl[i].e_fill > 0) ? 1 : 0);
            chk($sformatf("tbl%0d.idx", i),   int'(out_idx), tbl[i].e_idx);
            chk($sformatf("tbl%0d.held", i),  int'(key_held), tbl[i].e_held);
            chk($sformatf("tbl%0d.ovf", i),   int'(overflow), 0);
        end
        for (int i = 0; i < 3; i++) step("drain_tbl", 8'h00, 0, 1);
        chk("tbl_drained", int'(fill), 0);

        // Five letters into a depth-4 queue with the consumer stalled
        do_reset("reset1");
        ov_codes = '{32'h1C, 32'h32, 32'h21, 32'h23, 32'h24};
        ovf_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step("ovf_make", 8'(ov_codes[i]), 1, 0);
            if (overflow) ovf_seen++;
            chk($sformatf("ovf_pulse%0d", i), int'(overflow), (i == 4) ? 1 : 0);
            step("ovf_f0", 8'hF0, 1, 0);
            if (overflow) ovf_seen++;
            step("ovf_brk", 8'(ov_codes[i]), 1, 0);
            if (overflow) ovf_seen++;
        end
        chk("ovf_count", ovf_seen, 1);
        chk("ovf_fill", int'(fill), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_drain%0d", k), int'(out_idx), k + 1);
            step("ovf_drain", 8'h00, 0, 1);
        end
        chk("ovf_empty", int'(fill), 0);

        // Full queue, push and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            step("full_make", 8'(ov_codes[i]), 1, 0);
            step("full_f0", 8'hF0, 1, 0);
            step("full_brk", 8'(ov_codes[i]), 1, 0);
        end
        chk("full_fill", int'(fill), 4);
        step("full_pushpop", 8'h2B, 1, 1);
        chk("full_pp_ovf", int'(overflow), 0);
        chk("full_pp_fill", int'(fill), 4);
        exp_a = '{2, 3, 4, 6};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("full_drain%0d", k), int'(out_idx), exp_a[k]);
            step("full_drain", 8'h00, 0, 1);
        end

        // Reset in the middle of a break prefix
        step("mid_make", 8'h1C, 1, 0);
        step("mid_f0", 8'hF0, 1, 0);
        do_reset("mid_reset");
        step("mid_after", 8'h32, 1, 0);
        chk("mid_idx", int'(out_idx), 2);
        chk("mid_fill", int'(fill), 1);
        chk("mid_held", int'(key_held), 1);
        step("mid_drain", 8'h00, 0, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(9))
                0, 1, 2, 3: rb = codes[$urandom_range(5)];
                4, 5:       rb = 8'hF0;
                6:          rb = 8'hE0;
                default:    rb = 8'($urandom_range(255));
            endcase
            step("rand", rb, ($urandom_range(9) < 7), ($urandom_range(9) < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
